// File: rtl/alu_seq_controller.sv
// Multi-cycle sequencer in front of the ALU control stage: accepts one
// instruction, then steps DECODE -> EXECUTE -> WRITEBACK, driving register
// file strobes and ALUOp, and counts retired instructions.
module alu_seq_controller #(
    parameter int unsigned REG_AW = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2+3*REG_AW-1:0]   instr,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    input  logic                    wb_stall,
    output logic                    rf_rd_en,
    output logic [REG_AW-1:0]       rs_addr,
    output logic [REG_AW-1:0]       rt_addr,
    output logic                    alu_en,
    output logic [1:0]              ALUOp,
    output logic                    rf_wr_en,
    output logic [REG_AW-1:0]       rd_addr,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        instr_count
);

    localparam int unsigned IW = 2 + 3 * REG_AW;

    typedef enum logic [1:0] {
        StIdle,
        StDecode,
        StExecute,
        StWriteback
    } state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     ir_q, ir_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [1:0]        ir_op;
    logic [REG_AW-1:0] ir_rd, ir_rs, ir_rt;

    // IR field layout: op in the MSBs, then rd, rs, rt (rt in the LSBs).
    assign ir_op = ir_q[IW-1 -: 2];
    assign ir_rd = ir_q[3*REG_AW-1 -: REG_AW];
    assign ir_rs = ir_q[2*REG_AW-1 -: REG_AW];
    assign ir_rt = ir_q[REG_AW-1:0];

    // State, instruction register and retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and Moore output decode; done/rf_wr_en also see wb_stall.
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        cnt_d       = cnt_q;
        instr_ready = 1'b0;
        rf_rd_en    = 1'b0;
        rs_addr     = '0;
        rt_addr     = '0;
        alu_en      = 1'b0;
        ALUOp       = 2'b00;
        rf_wr_en    = 1'b0;
        rd_addr     = '0;
        done        = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Held low while reset is asserted so every output reads 0.
                instr_ready = rst_n;
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                rf_rd_en = 1'b1;
                rs_addr  = ir_rs;
                rt_addr  = ir_rt;
                state_d  = StExecute;
            end
            StExecute: begin
                alu_en  = 1'b1;
                ALUOp   = ir_op;
                state_d = StWriteback;
            end
            StWriteback: begin
                rd_addr = ir_rd;
                if (!wb_stall) begin
                    // Register 0 is hardwired zero: retire without writing.
                    rf_wr_en = (ir_rd != '0);
                    done     = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy        = (state_q != StIdle);
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_alu_seq_controller.sv
// Bench for alu_seq_controller: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_alu_seq_controller;

    logic       clk;
    logic       rst_n;
    logic [7:0] instr;
    logic       instr_valid;
    logic       wb_stall;

    logic       instr_ready, rf_rd_en, alu_en, rf_wr_en, busy, done;
    logic [1:0] rs_addr, rt_addr, rd_addr, ALUOp;
    logic [7:0] instr_count;

    // Second instance with a 2-bit counter to exercise wrap-around.
    logic       instr_ready2, rf_rd_en2, alu_en2, rf_wr_en2, busy2, done2;
    logic [1:0] rs_addr2, rt_addr2, rd_addr2, ALUOp2;
    logic [1:0] instr_count2;

    int n_chk  = 0;
    int n_fail = 0;

    alu_seq_controller #(.REG_AW(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .wb_stall(wb_stall), .rf_rd_en(rf_rd_en),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .alu_en(alu_en), .ALUOp(ALUOp),
        .rf_wr_en(rf_wr_en), .rd_addr(rd_addr), .busy(busy), .done(done),
        .instr_count(instr_count)
    );

    alu_seq_controller #(.REG_AW(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready2), .wb_stall(wb_stall), .rf_rd_en(rf_rd_en2),
        .rs_addr(rs_addr2), .rt_addr(rt_addr2), .alu_en(alu_en2), .ALUOp(ALUOp2),
        .rf_wr_en(rf_wr_en2), .rd_addr(rd_addr2), .busy(busy2), .done(done2),
        .instr_count(instr_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an accepted instruction has an age in cycles
    // (1 = decode, 2 = execute, 3 = writeback, stays 3 while stalled).
    logic m_busy = 1'b0;
    int   m_age  = 0;
    int   m_op = 0, m_rd = 0, m_rs = 0, m_rt = 0;
    int   m_cnt  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_age  <= 0;
            m_cnt  <= 0;
        end else if (!m_busy) begin
            if (instr_valid) begin
                m_busy <= 1'b1;
                m_age  <= 1;
                m_op   <= int'(instr) / 64;
                m_rd   <= (int'(instr) / 16) % 4;
                m_rs   <= (int'(instr) / 4) % 4;
                m_rt   <= int'(instr) % 4;
            end
        end else if (m_age < 3) begin
            m_age <= m_age + 1;
        end else if (!wb_stall) begin
            m_busy <= 1'b0;
            m_cnt  <= m_cnt + 1;
        end
    end

    // Compare both instances against the model in the middle of every cycle.
    always @(negedge clk) begin
        int  ph;
        logic e_done;
        ph     = m_busy ? m_age : 0;
        e_done = (ph == 3) && !wb_stall;
        check("instr_ready", int'(instr_ready), int'(rst_n && !m_busy));
        check("busy",        int'(busy),        int'(m_busy));
        check("rf_rd_en",    int'(rf_rd_en),    int'(ph == 1));
        check("rs_addr",     int'(rs_addr),     (ph == 1) ? m_rs : 0);
        check("rt_addr",     int'(rt_addr),     (ph == 1) ? m_rt : 0);
        check("alu_en",      int'(alu_en),      int'(ph == 2));
        check("ALUOp",       int'(ALUOp),       (ph == 2) ? m_op : 0);
        check("rd_addr",     int'(rd_addr),     (ph == 3) ? m_rd : 0);
        check("done",        int'(done),        int'(e_done));
        check("rf_wr_en",    int'(rf_wr_en),    int'(e_done && m_rd != 0));
        check("instr_count", int'(instr_count), m_cnt % 256);
        check("count_w2",    int'(instr_count2), m_cnt % 4);
        check("done_w2",     int'(done2),       int'(e_done));
    end

    // Issue one instruction starting at posedge+1 in IDLE; garbage is driven
    // on instr/instr_valid while busy. Returns edge-to-done latency.
    task automatic run_instr(input logic [7:0] word, input int stall,
                             output int lat, output int op_seen, output int wr_seen);
        instr       = word;
        instr_valid = 1'b1;
        wb_stall    = (stall > 0);
        lat     = -1;
        op_seen = -1;
        wr_seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            instr_valid = 1'($urandom % 2);
            instr       = 8'($urandom);
            if (n == 2 + stall) wb_stall = 1'b0;
            @(negedge clk);
            if (alu_en) op_seen = int'(ALUOp);
            if (rf_wr_en) wr_seen = 1;
            if (done) begin
                lat = n + 1;
                break;
            end
        end
        check("done_timeout", int'(lat > 0), 1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    int lat, op_seen, wr_seen;
    logic [7:0] word;

    initial begin
        instr       = 8'h00;
        instr_valid = 1'b0;
        wb_stall    = 1'b0;
        rst_n       = 1'b1;
        #1 rst_n    = 1'b0;
        @(negedge clk);
        check("rst_ready", int'(instr_ready), 0);
        check("rst_busy",  int'(busy), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("post_rst_ready", int'(instr_ready), 1);
        check("post_rst_count", int'(instr_count), 0);
        @(posedge clk);
        #1;

        // Single instruction, op=01 rd=2 rs=1 rt=3.
        instr       = 8'b01_10_01_11;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        check("t1_rd_en", int'(rf_rd_en), 1);
        check("t1_rs",    int'(rs_addr), 1);
        check("t1_rt",    int'(rt_addr), 3);
        @(negedge clk);
        check("t1_alu_en", int'(alu_en), 1);
        check("t1_aluop",  int'(ALUOp), 1);
        @(negedge clk);
        check("t1_wr_en", int'(rf_wr_en), 1);
        check("t1_rd",    int'(rd_addr), 2);
        check("t1_done",  int'(done), 1);
        @(negedge clk);
        check("t1_count", int'(instr_count), 1);
        check("t1_ready", int'(instr_ready), 1);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of EXECUTE.
        instr       = 8'b10_11_01_10;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("ar_alu_en", int'(alu_en), 0);
        check("ar_aluop",  int'(ALUOp), 0);
        check("ar_busy",   int'(busy), 0);
        check("ar_ready",  int'(instr_ready), 0);
        check("ar_count",  int'(instr_count), 0);
        #10 rst_n = 1'b1;
        #1;
        check("ar_rel_ready", int'(instr_ready), 1);
        @(posedge clk);
        #1;

        // Four back-to-back ops, then an rd=0 instruction; 2-bit counter wraps.
        for (int i = 0; i < 4; i++) begin
            word = 8'((i * 64) + 8'b00_01_10_11);
            run_instr(word, 0, lat, op_seen, wr_seen);
            check("b2b_latency", lat, 3);
            check("b2b_aluop",   op_seen, i);
            check("b2b_wr",      wr_seen, 1);
            check("b2b_count",   int'(instr_count), i + 1);
            check("wrap_count",  int'(instr_count2), (i == 3) ? 0 : i + 1);
        end
        run_instr(8'b11_00_10_01, 0, lat, op_seen, wr_seen);
        check("rd0_latency", lat, 3);
        check("rd0_no_write", wr_seen, 0);
        check("rd0_count",   int'(instr_count), 5);
        check("wrap_count5", int'(instr_count2), 1);

        // Three stalled writeback cycles.
        run_instr(8'b00_01_11_10, 3, lat, op_seen, wr_seen);
        check("stall_latency", lat, 6);
        check("stall_wr",      wr_seen, 1);
        check("stall_count",   int'(instr_count), 6);

        // Randomized traffic against the model.
        repeat (600) begin
            instr_valid = 1'($urandom % 2);
            instr       = 8'($urandom);
            wb_stall    = ($urandom % 3) == 0;
            @(posedge clk);
            #1;
        end
        wb_stall    = 1'b0;
        instr_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
